// File: rtl/control_sequencer_pkg.sv
// cpu_pkg: opcodes, IR field positions, T-step encoding and instruction classes shared by the control sequencer
package cpu_pkg;
    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    localparam logic [4:0] OP_ADD  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ROR  = 5'b01100;
    localparam logic [4:0] OP_ROL  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b10001;
    localparam logic [4:0] OP_DIV  = 5'b10010;
    localparam logic [4:0] OP_NEG  = 5'b10011;
    localparam logic [4:0] OP_NOT  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT} t_step_e;

    typedef enum logic [2:0] {CLS_BIN, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL} t_class_e;

    function automatic t_class_e op_class(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL} ? CLS_BIN :
               op inside {OP_MUL, OP_DIV} ? CLS_MULDIV :
               op inside {OP_NEG, OP_NOT} ? CLS_UNARY :
               op == OP_NOP ? CLS_NOP :
               op == OP_HALT ? CLS_HALT : CLS_ILLEGAL;
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/memory status in, datapath strobes out
//   master: sequencer side (reads ir, mem_ready; drives strobes, alu_op, run, illegal, tstep)
//   slave : datapath side
interface control_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
);
    logic [31:0]         ir;
    logic                mem_ready;
    logic [NUM_REGS-1:0] r_in;
    logic [NUM_REGS-1:0] r_out;
    logic                pc_out;
    logic                mdr_out;
    logic                zlow_out;
    logic                zhigh_out;
    logic                mar_in;
    logic                mdr_in;
    logic                ir_in;
    logic                pc_in;
    logic                hi_in;
    logic                lo_in;
    logic                y_en;
    logic                z_en;
    logic                pc_inc;
    logic                mdr_read;
    logic [OPW-1:0]      alu_op;
    logic                run;
    logic                illegal;
    logic [2:0]          tstep;

    modport master (
        input  ir, mem_ready,
        output r_in, r_out, pc_out, mdr_out, zlow_out, zhigh_out, mar_in, mdr_in, ir_in, pc_in,
               hi_in, lo_in, y_en, z_en, pc_inc, mdr_read, alu_op, run, illegal, tstep
    );

    modport slave (
        output ir, mem_ready,
        input  r_in, r_out, pc_out, mdr_out, zlow_out, zhigh_out, mar_in, mdr_in, ir_in, pc_in,
               hi_in, lo_in, y_en, z_en, pc_inc, mdr_read, alu_op, run, illegal, tstep
    );
endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// reg_select_decoder: 4-bit register index to NUM_REGS one-hot select, gated by en
//   en in 1, idx in 4, onehot out NUM_REGS (all zero for an index outside NUM_REGS)
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic                en,
    input  logic [3:0]          idx,
    output logic [NUM_REGS-1:0] onehot
);
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        assign onehot[i] = en && (32'(idx) == i);
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit, one micro-step per clock
//   clk, clr (sync active-high reset); bus: control_sequencer_if.master (ir, mem_ready in; strobes out)
//   CONTROL_SEQUENCER_STEP_EN adds input step: T0 waits for step=1 before starting an instruction
module control_sequencer import cpu_pkg::*; #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic clk,
    input  logic clr,
`ifdef CONTROL_SEQUENCER_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);
    t_step_e  state, nxt;
    t_class_e cls;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc, rout_idx;
    logic go, act, is_bin, is_md, is_un;
    logic t0, t1, t2, t3, t4, t5, t6, alu_step, rout_en, rin_en;
    logic unused_ir;

    assign opcode    = bus.ir[IR_OP_HI:IR_OP_LO];
    assign ra        = bus.ir[IR_RA_HI:IR_RA_LO];
    assign rb        = bus.ir[IR_RB_HI:IR_RB_LO];
    assign rc        = bus.ir[IR_RC_HI:IR_RC_LO];
    assign unused_ir = ^bus.ir[IR_RC_LO-1:0];
    assign cls       = op_class(opcode);
    assign is_bin    = cls == CLS_BIN;
    assign is_md     = cls == CLS_MULDIV;
    assign is_un     = cls == CLS_UNARY;
    assign act       = !clr;

`ifdef CONTROL_SEQUENCER_STEP_EN
    assign go = state != ST_T0 || step;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk)
        state <= clr ? ST_T0 : nxt;

    always_comb begin
        nxt = state;
        case (state)
            ST_T0:   nxt = go ? ST_T1 : ST_T0;
            ST_T1:   nxt = bus.mem_ready ? ST_T2 : ST_T1;
            ST_T2:   nxt = ST_T3;
            ST_T3:   nxt = is_bin || is_md ? ST_T4 : is_un ? ST_T5 : cls == CLS_HALT ? ST_HALT : ST_T0;
            ST_T4:   nxt = ST_T5;
            ST_T5:   nxt = is_md ? ST_T6 : ST_T0;
            ST_T6:   nxt = ST_T0;
            default: nxt = ST_HALT;
        endcase
    end

    always_comb begin
        t0            = act && state == ST_T0 && go;
        t1            = act && state == ST_T1;
        t2            = act && state == ST_T2;
        t3            = act && state == ST_T3;
        t4            = act && state == ST_T4;
        t5            = act && state == ST_T5;
        t6            = act && state == ST_T6;
        // unary ops compute in T3; binary and mul/div compute in T4
        alu_step      = (t3 && is_un) || (t4 && (is_bin || is_md));
        rout_en       = (t3 && (is_bin || is_md || is_un)) || (t4 && (is_bin || is_md));
        rout_idx      = state == ST_T3 ? (is_md ? ra : rb) : (is_md ? rb : rc);
        rin_en        = t5 && (is_bin || is_un);
        bus.pc_out    = t0;
        bus.mar_in    = t0;
        bus.pc_inc    = t0;
        bus.z_en      = t0 || alu_step;
        bus.zlow_out  = t1 || t5;
        bus.pc_in     = t1;
        bus.mdr_read  = t1;
        bus.mdr_in    = t1;
        bus.mdr_out   = t2;
        bus.ir_in     = t2;
        bus.y_en      = t3 && (is_bin || is_md);
        bus.lo_in     = t5 && is_md;
        bus.zhigh_out = t6;
        bus.hi_in     = t6;
        bus.illegal   = t3 && cls == CLS_ILLEGAL;
        bus.alu_op    = alu_step ? OPW'(opcode) : '0;
        bus.run       = clr || (state != ST_HALT && go);
        bus.tstep     = act ? state : ST_T0;
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout (.en(rout_en), .idx(rout_idx), .onehot(bus.r_out));
    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin  (.en(rin_en),  .idx(ra),       .onehot(bus.r_in));
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized instruction streams checked cycle by cycle against a step-table model
module tb_control_sequencer;
    typedef struct packed {
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic pc_out, mdr_out, zlow_out, zhigh_out, mar_in, mdr_in, ir_in, pc_in;
        logic hi_in, lo_in, y_en, z_en, pc_inc, mdr_read;
        logic [4:0] alu_op;
        logic run, illegal;
        logic [2:0] tstep;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
`ifdef CONTROL_SEQUENCER_STEP_EN
    logic step = 1'b1;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    vec_t q[$];

    control_sequencer_if #(.NUM_REGS(16), .OPW(5)) bus();

    control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
        .clk(clk),
        .clr(clr),
`ifdef CONTROL_SEQUENCER_STEP_EN
        .step(step),
`endif
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic vec_t sample();
        vec_t v;
        v.r_in = bus.r_in; v.r_out = bus.r_out;
        v.pc_out = bus.pc_out; v.mdr_out = bus.mdr_out; v.zlow_out = bus.zlow_out; v.zhigh_out = bus.zhigh_out;
        v.mar_in = bus.mar_in; v.mdr_in = bus.mdr_in; v.ir_in = bus.ir_in; v.pc_in = bus.pc_in;
        v.hi_in = bus.hi_in; v.lo_in = bus.lo_in; v.y_en = bus.y_en; v.z_en = bus.z_en;
        v.pc_inc = bus.pc_inc; v.mdr_read = bus.mdr_read; v.alu_op = bus.alu_op;
        v.run = bus.run; v.illegal = bus.illegal; v.tstep = bus.tstep;
        return v;
    endfunction

    function automatic vec_t at(input logic [2:0] t);
        vec_t v = '0;
        v.run = 1'b1;
        v.tstep = t;
        return v;
    endfunction

    // expected per-cycle strobes for one instruction, written straight from the step table
    function automatic void build(input logic [31:0] ins, input int waits);
        vec_t v;
        logic [4:0] op = ins[31:27];
        int ra = int'(ins[26:23]);
        int rb = int'(ins[22:19]);
        int rc = int'(ins[18:15]);
        q.delete();
        v = at(0); v.pc_out = 1; v.mar_in = 1; v.pc_inc = 1; v.z_en = 1; q.push_back(v);
        for (int i = 0; i <= waits; i++) begin
            v = at(1); v.zlow_out = 1; v.pc_in = 1; v.mdr_read = 1; v.mdr_in = 1; q.push_back(v);
        end
        v = at(2); v.mdr_out = 1; v.ir_in = 1; q.push_back(v);
        if (op inside {5, 6, 7, 8, 9, 11, 12, 13}) begin
            v = at(3); v.r_out = 16'(1) << rb; v.y_en = 1; q.push_back(v);
            v = at(4); v.r_out = 16'(1) << rc; v.alu_op = op; v.z_en = 1; q.push_back(v);
            v = at(5); v.zlow_out = 1; v.r_in = 16'(1) << ra; q.push_back(v);
        end else if (op inside {17, 18}) begin
            v = at(3); v.r_out = 16'(1) << ra; v.y_en = 1; q.push_back(v);
            v = at(4); v.r_out = 16'(1) << rb; v.alu_op = op; v.z_en = 1; q.push_back(v);
            v = at(5); v.zlow_out = 1; v.lo_in = 1; q.push_back(v);
            v = at(6); v.zhigh_out = 1; v.hi_in = 1; q.push_back(v);
        end else if (op inside {19, 20}) begin
            v = at(3); v.r_out = 16'(1) << rb; v.alu_op = op; v.z_en = 1; q.push_back(v);
            v = at(5); v.zlow_out = 1; v.r_in = 16'(1) << ra; q.push_back(v);
        end else begin
            v = at(3); v.illegal = !(op inside {26, 27}); q.push_back(v);
        end
    endfunction

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0};
    endfunction

    // drives one instruction from T0; stops without advancing after ncyc cycles when ncyc > 0
    task automatic run_instr(input string name, input logic [31:0] ins, input int waits, input int ncyc);
        vec_t o;
        int waited = 0;
        build(ins, waits);
        bus.ir = ins;
        foreach (q[i]) begin
            if (q[i].tstep == 3'd1) begin
                bus.mem_ready = waited >= waits;
                waited++;
            end else bus.mem_ready = 1'b1;
            o = sample();
            n_cmp++;
            if (o !== q[i]) begin
                n_bad++;
                $display("FAIL %s cycle%0d: got %h want %h", name, i, o, q[i]);
            end
            n_cmp++;
            if ($countones({o.r_out, o.pc_out, o.mdr_out, o.zlow_out, o.zhigh_out}) > 1) begin
                n_bad++;
                $display("FAIL %s bus_drive cycle%0d: got %h want at most one drive", name, i, o);
            end
            if (i + 1 == ncyc) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        vec_t o;
        bus.ir = '0; bus.mem_ready = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        o = sample();
        n_cmp++;
        if (o !== at(0)) begin n_bad++; $display("FAIL reset_hold: got %h want %h", o, at(0)); end
        @(posedge clk); #1;
        clr = 1'b0; #1;
        o = sample();
        n_cmp++;
        if (o.tstep !== 3'd0 || o.pc_out !== 1'b1 || o.run !== 1'b1) begin
            n_bad++; $display("FAIL reset_release: got %h want T0 strobes", o);
        end
    endtask

    task automatic test_add();
        run_instr("add", 32'h28980000, 0, 0);
        run_instr("add_r15", mk(5, 15, 0, 14), 0, 0);
    endtask

    task automatic test_mul();
        run_instr("mul", mk(17, 5, 7, 0), 0, 0);
        run_instr("div", mk(18, 0, 15, 3), 1, 0);
    endtask

    task automatic test_neg();
        run_instr("neg", mk(19, 1, 2, 0), 0, 0);
        run_instr("not", mk(20, 9, 4, 0), 0, 0);
    endtask

    task automatic test_wait();
        run_instr("add_wait3", 32'h28980000, 3, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_1f", mk(31, 1, 2, 3), 0, 0);
        run_instr("illegal_shra", mk(10, 1, 2, 3), 0, 0);
        run_instr("nop", mk(26, 1, 2, 3), 0, 0);
    endtask

    task automatic test_clr_mid();
        vec_t o;
        run_instr("add_pre_clr", 32'h28980000, 0, 5);
        clr = 1'b1; #1;
        o = sample();
        n_cmp++;
        if (o !== at(0)) begin n_bad++; $display("FAIL clr_in_t4: got %h want %h", o, at(0)); end
        @(posedge clk); #1;
        o = sample();
        n_cmp++;
        if (o !== at(0) || o.r_in !== 16'h0) begin n_bad++; $display("FAIL clr_next: got %h want %h", o, at(0)); end
        clr = 1'b0; #1;
        run_instr("add_post_clr", 32'h28980000, 0, 0);
    endtask

    task automatic test_random();
        int ops[17] = '{5, 6, 7, 8, 9, 11, 12, 13, 17, 18, 19, 20, 26, 0, 10, 31, 15};
        for (int k = 0; k < 60; k++)
            run_instr("random", mk(ops[$urandom_range(16)], $urandom_range(15), $urandom_range(15),
                      $urandom_range(15)), $urandom_range(3), 0);
    endtask

    task automatic test_halt();
        vec_t o;
        vec_t h = '0;
        h.tstep = 3'd7;
        run_instr("halt", mk(27, 0, 0, 0), 0, 0);
        for (int k = 0; k < 5; k++) begin
            o = sample();
            n_cmp++;
            if (o !== h) begin n_bad++; $display("FAIL halt_hold%0d: got %h want %h", k, o, h); end
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; #1;
        o = sample();
        n_cmp++;
        if (o.run !== 1'b1 || o.tstep !== 3'd0) begin n_bad++; $display("FAIL halt_clr: got %h want run=1 T0", o); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_neg();
        test_wait();
        test_illegal();
        test_clr_mid();
        test_random();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
